alu_mul_ctrl: RTL and testbench
===============================

# alu_mul_ctrl

Multi-cycle 16×16 unsigned multiply sequencer that drives the shared 16-bit ALU as its adder, producing a 32-bit product by shift-and-add. It sits beside the ALU in the CPU datapath and owns the ALU's operand and control inputs while a multiply is in progress. The integer ALU itself stays purely combinational; all sequencing, shifting and product storage live here.

## Interface
- No parameters; widths fixed at 16-bit operands and 32-bit product.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request a multiply; sampled only when Busy=0.
- Multiplicand  in  16  operand M, captured on accepted Start.
- Multiplier  in  16  operand Q, captured on accepted Start.
- Busy  out  1  high while iterating (RUN state).
- Done  out  1  one-cycle pulse; Product valid from this cycle on.
- Product  out  32  result {Hi,Lo}; holds until next accepted Start.
- AluA  out  16  ALU A operand.
- AluB  out  16  ALU B operand.
- AluOp  out  3  ALU operation select.
- AluAInvert  out  1  ALU A invert; constant 0.
- AluBNegate  out  1  ALU B negate / carry-in; constant 0.
- AluResult  in  16  ALU Result, combinational from the ALU outputs above.
- AluCarryOut  in  1  ALU CarryOut.

## Operation
- Registers: Mreg[15:0], Hi[15:0], Lo[15:0], Cnt[3:0], state.
- States: IDLE, RUN, DONE.
- IDLE or DONE with Start=1: Mreg←Multiplicand, Hi←0, Lo←Multiplier, Cnt←0, go to RUN.
- IDLE with Start=0: stay in IDLE.
- DONE with Start=0: go to IDLE.
- RUN, every cycle:
  - Drive AluA=Hi, AluB = Lo[0] ? Mreg : 0, AluOp=ADD.
  - Update {Hi,Lo} ← {AluCarryOut, AluResult, Lo[15:1]}: a 33-bit right shift.
  - Cnt←Cnt+1.
  - When Cnt=15 (16th iteration), go to DONE.
- Start during RUN is ignored; it is not queued.
- Product = {Hi,Lo} at all times. Its value is meaningful only from Done onward.
- ALU outputs outside RUN: AluA=0, AluB=0, AluOp=ADD, AluAInvert=0, AluBNegate=0.
- Arithmetic: the sum is 17 bits (carry + 16). Unsigned only; the ALU's Overflow and Zero outputs are not used.
- Reset (any state, including mid-RUN):
  - State→IDLE.
  - Mreg, Hi, Lo, Cnt cleared.
  - Busy=0, Done=0, Product=0.
  - Any operation in flight is abandoned with no Done.

## Timing
- Start accepted at edge N.
- RUN occupies the cycles after edges N..N+15, i.e. 16 iterations.
- Busy is high for exactly 16 cycles.
- Done is high for exactly one cycle, after edge N+16, with the final Product.
- Latency: accepted Start to Done = 17 cycles.
- Back-to-back: Start asserted in the Done cycle is accepted, so the next Busy immediately follows Done. Product then starts being overwritten.
- ALU path is combinational within one cycle: AluA/AluB (registered) → ALU → AluResult/AluCarryOut → Hi/Lo D-inputs. This ripple path is the block's critical path.

## Structure
- Shared package `cpu_pkg` holds:
  - ALU opcode constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010.
  - The state encoding for IDLE, RUN and DONE.
- No sub-module. The ALU is instantiated by the parent, which muxes ALU inputs between the main datapath and this block using Busy.
- The bench instantiates ALU16 alongside this block to close the loop.

## Test plan
- Reset, then Multiplicand=3, Multiplier=5, Start one cycle → Busy high 16 cycles, Done pulse 17 cycles after Start, Product=32'h0000000F.
- 16'hFFFF × 16'hFFFF → Product=32'hFFFE0001. Checks that the carry is shifted into Hi[15].
- 0 × 16'h1234 and 16'h1234 × 0 → Product=0. AluB=0 on every RUN cycle of the second case.
- Start held high continuously with 16'h0100 × 16'h0100 → Product=32'h00010000 at Done. A new operation begins the cycle after Done; the pulse in the Done cycle is the accepted one, and Start pulses during Busy are ignored.
- Reset asserted at iteration 8 → next cycle Busy=0, Product=0, no Done. A following 7×9 → 32'h0000003F.
- Idle check → AluA, AluB, AluAInvert and AluBNegate are 0 and AluOp=ALU_ADD whenever Busy=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU opcodes and multiply sequencer state encoding
package cpu_pkg;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/alu16.sv
// ALU16: combinational 16-bit integer ALU (AND, OR, ADD with A invert / B negate)
module ALU16
    import cpu_pkg::*;
(
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [2:0]  Op,
    input  logic        AInvert,
    input  logic        BNegate,
    output logic [15:0] Result,
    output logic        CarryOut,
    output logic        Overflow,
    output logic        Zero
);
    logic [15:0] a_eff;
    logic [15:0] b_eff;
    logic [16:0] sum;
    // Operand conditioning, adder and result select
    always_comb begin
        a_eff    = AInvert ? ~A : A;
        b_eff    = BNegate ? ~B : B;
        sum      = {1'b0, a_eff} + {1'b0, b_eff} + {16'd0, BNegate};
        Result   = (Op == ALU_AND) ? (a_eff & b_eff) :
                   (Op == ALU_OR)  ? (a_eff | b_eff) :
                   (Op == ALU_ADD) ? sum[15:0] : 16'd0;
        CarryOut = (Op == ALU_ADD) ? sum[16] : 1'b0;
        Overflow = (Op == ALU_ADD) && (a_eff[15] == b_eff[15]) && (sum[15] != a_eff[15]);
        Zero     = (Result == 16'd0);
    end
endmodule

// File: rtl/alu_mul_ctrl.sv
// alu_mul_ctrl: 16x16 unsigned shift-and-add multiplier borrowing the shared ALU as its adder
module alu_mul_ctrl
    import cpu_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Multiplicand,
    input  logic [15:0] Multiplier,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Product,
    output logic [15:0] AluA,
    output logic [15:0] AluB,
    output logic [2:0]  AluOp,
    output logic        AluAInvert,
    output logic        AluBNegate,
    input  logic [15:0] AluResult,
    input  logic        AluCarryOut
);
    mul_state_t state, state_d;
    logic [15:0] mreg, hi, lo;
    logic [3:0]  cnt;
    logic        accept;

    assign accept = (state != ST_RUN) && Start;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Next state: load from IDLE/DONE, 16 iterations in RUN, DONE lasts one cycle
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: state_d = Start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = (cnt == 4'd15) ? ST_DONE : ST_RUN;
            ST_DONE: state_d = Start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture and 33-bit right shift of {carry, sum, Lo} each iteration
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mreg <= '0;
            hi   <= '0;
            lo   <= '0;
            cnt  <= '0;
        end else if (accept) begin
            mreg <= Multiplicand;
            hi   <= '0;
            lo   <= Multiplier;
            cnt  <= '0;
        end else if (state == ST_RUN) begin
            {hi, lo} <= {AluCarryOut, AluResult, lo[15:1]};
            cnt      <= cnt + 4'd1;
        end
    end

    // Status and ALU drive; ALU inputs are forced to a benign ADD of zeros outside RUN
    always_comb begin
        Busy       = (state == ST_RUN);
        Done       = (state == ST_DONE);
        Product    = {hi, lo};
        AluA       = Busy ? hi : 16'd0;
        AluB       = (Busy && lo[0]) ? mreg : 16'd0;
        AluOp      = ALU_ADD;
        AluAInvert = 1'b0;
        AluBNegate = 1'b0;
    end
endmodule

// File: tb/tb_alu_mul_ctrl.sv
// tb_alu_mul_ctrl: directed self-checking bench for the multiply sequencer closed around ALU16
module tb_alu_mul_ctrl;
    import cpu_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [15:0] Multiplicand = '0;
    logic [15:0] Multiplier = '0;
    logic        Busy, Done;
    logic [31:0] Product;
    logic [15:0] AluA, AluB, AluResult;
    logic [2:0]  AluOp;
    logic        AluAInvert, AluBNegate, AluCarryOut, AluOverflow, AluZero;

    int checks = 0;
    int failures = 0;

    always #5 Clock = ~Clock;

    alu_mul_ctrl dut (
        .Clock(Clock), .Reset(Reset), .Start(Start),
        .Multiplicand(Multiplicand), .Multiplier(Multiplier),
        .Busy(Busy), .Done(Done), .Product(Product),
        .AluA(AluA), .AluB(AluB), .AluOp(AluOp),
        .AluAInvert(AluAInvert), .AluBNegate(AluBNegate),
        .AluResult(AluResult), .AluCarryOut(AluCarryOut)
    );

    ALU16 alu (
        .A(AluA), .B(AluB), .Op(AluOp), .AInvert(AluAInvert), .BNegate(AluBNegate),
        .Result(AluResult), .CarryOut(AluCarryOut), .Overflow(AluOverflow), .Zero(AluZero)
    );

    // Runs one multiply from a one-cycle Start pulse and reports what was observed
    task automatic run_mul(input logic [15:0] m, input logic [15:0] q,
                           output logic [31:0] p, output logic [31:0] p_hold,
                           output int lat, output int busy_n, output logic alub_nz,
                           output logic idle_alu_bad, output logic done_next);
        @(posedge Clock); #1;
        Multiplicand = m; Multiplier = q; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; Multiplicand = ~m; Multiplier = ~q;
        lat = 0; busy_n = 0; alub_nz = 1'b0; idle_alu_bad = 1'b0; p = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (Busy) busy_n++;
            if (Busy && AluB != 16'd0) alub_nz = 1'b1;
            if (Done) begin
                lat = c;
                p = Product;
                idle_alu_bad = (AluA != 16'd0) || (AluB != 16'd0) || (AluOp != ALU_ADD) ||
                               AluAInvert || AluBNegate;
                break;
            end
        end
        @(negedge Clock);
        done_next = Done;
        p_hold = Product;
    endtask

    task automatic test_reset();
        @(posedge Clock); #1;
        Reset = 1'b1; Start = 1'b0; Multiplicand = 16'hA5A5; Multiplier = 16'h5A5A;
        repeat (2) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status busy=%b done=%b expected 0 0", Busy, Done);
        end
        checks++;
        if (Product !== 32'd0) begin
            failures++;
            $display("FAIL reset_product got=%h expected=00000000", Product);
        end
    endtask

    task automatic test_idle_alu();
        logic bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            if (Busy !== 1'b0 || AluA !== 16'd0 || AluB !== 16'd0 || AluOp !== ALU_ADD ||
                AluAInvert !== 1'b0 || AluBNegate !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL idle_alu a=%h b=%h op=%b ainv=%b bneg=%b expected 0 0 %b 0 0",
                     AluA, AluB, AluOp, AluAInvert, AluBNegate, ALU_ADD);
        end
    endtask

    task automatic test_basic();
        logic [31:0] p, ph;
        int lat, bn;
        logic bnz, ibad, dn;
        run_mul(16'd3, 16'd5, p, ph, lat, bn, bnz, ibad, dn);
        checks++;
        if (bn !== 16) begin
            failures++;
            $display("FAIL basic_busy_cycles got=%0d expected=16", bn);
        end
        checks++;
        if (lat !== 17) begin
            failures++;
            $display("FAIL basic_latency got=%0d expected=17", lat);
        end
        checks++;
        if (p !== 32'h0000000F) begin
            failures++;
            $display("FAIL basic_product got=%h expected=0000000f", p);
        end
        checks++;
        if (dn !== 1'b0 || ph !== 32'h0000000F) begin
            failures++;
            $display("FAIL basic_done_pulse done_next=%b hold=%h expected 0 0000000f", dn, ph);
        end
        checks++;
        if (ibad) begin
            failures++;
            $display("FAIL done_cycle_alu a=%h b=%h op=%b expected 0 0 %b", AluA, AluB, AluOp, ALU_ADD);
        end
    endtask

    task automatic test_carry();
        logic [31:0] p, ph;
        int lat, bn;
        logic bnz, ibad, dn;
        run_mul(16'hFFFF, 16'hFFFF, p, ph, lat, bn, bnz, ibad, dn);
        checks++;
        if (p !== 32'hFFFE0001 || lat !== 17) begin
            failures++;
            $display("FAIL carry_product got=%h lat=%0d expected=fffe0001 lat=17", p, lat);
        end
        run_mul(16'h00FF, 16'h0101, p, ph, lat, bn, bnz, ibad, dn);
        checks++;
        if (p !== 32'h0000FFFF) begin
            failures++;
            $display("FAIL mixed_product got=%h expected=0000ffff", p);
        end
    endtask

    task automatic test_zero();
        logic [31:0] p, ph;
        int lat, bn;
        logic bnz, ibad, dn;
        run_mul(16'h0000, 16'h1234, p, ph, lat, bn, bnz, ibad, dn);
        checks++;
        if (p !== 32'd0 || lat !== 17) begin
            failures++;
            $display("FAIL zero_m_product got=%h lat=%0d expected=00000000 lat=17", p, lat);
        end
        run_mul(16'h1234, 16'h0000, p, ph, lat, bn, bnz, ibad, dn);
        checks++;
        if (p !== 32'd0 || lat !== 17) begin
            failures++;
            $display("FAIL zero_q_product got=%h lat=%0d expected=00000000 lat=17", p, lat);
        end
        checks++;
        if (bnz !== 1'b0) begin
            failures++;
            $display("FAIL zero_q_alub got nonzero AluB in RUN expected always 0000");
        end
    endtask

    task automatic test_back_to_back();
        int lat = 0;
        int lat2 = 0;
        logic [31:0] p = '0;
        @(posedge Clock); #1;
        Multiplicand = 16'h0100; Multiplier = 16'h0100; Start = 1'b1;
        @(posedge Clock); #1;
        Multiplicand = 16'd2; Multiplier = 16'd3;
        for (int c = 1; c <= 40; c++) begin
            @(negedge Clock);
            if (Done) begin
                lat = c;
                p = Product;
                break;
            end
        end
        checks++;
        if (lat !== 17 || p !== 32'h00010000) begin
            failures++;
            $display("FAIL b2b_first got=%h lat=%0d expected=00010000 lat=17", p, lat);
        end
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b1 || Done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart busy=%b done=%b expected 1 0", Busy, Done);
        end
        Start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (Done) begin
                lat2 = c;
                break;
            end
            @(negedge Clock);
        end
        checks++;
        if (lat2 !== 17 || Product !== 32'h00000006) begin
            failures++;
            $display("FAIL b2b_second got=%h lat=%0d expected=00000006 lat=17", Product, lat2);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] p, ph;
        int lat, bn;
        logic bnz, ibad, dn;
        logic saw_done = 1'b0;
        @(posedge Clock); #1;
        Multiplicand = 16'h1234; Multiplier = 16'h5678; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (7) @(posedge Clock);
        #1 Reset = 1'b1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 32'd0) begin
            failures++;
            $display("FAIL midreset_state busy=%b done=%b product=%h expected 0 0 00000000",
                     Busy, Done, Product);
        end
        for (int i = 0; i < 25; i++) begin
            @(negedge Clock);
            if (Done || Busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL midreset_abandon got busy/done after reset expected none");
        end
        run_mul(16'd7, 16'd9, p, ph, lat, bn, bnz, ibad, dn);
        checks++;
        if (p !== 32'h0000003F || lat !== 17) begin
            failures++;
            $display("FAIL midreset_next got=%h lat=%0d expected=0000003f lat=17", p, lat);
        end
    endtask

    initial begin
        test_reset();
        test_idle_alu();
        test_basic();
        test_carry();
        test_zero();
        test_back_to_back();
        test_reset_mid();
        test_idle_alu();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
